matmul_result_requant: RTL
==========================

# matmul_result_requant

Downstream drain stage for `tiled_matmul_engine`, started after its `done` pulse. It reads the 32-bit accumulator result matrix (`mem_c_acc`) in row-major order through a synchronous read port. Each element is requantized to signed `DATA_WIDTH` using a multiply, a rounding right-shift and saturation. Results stream out on a valid/ready interface with full backpressure support.

## Interface
- `DATA_WIDTH`, 8: output element width (signed)
- `ACC_WIDTH`, 32: accumulator width (signed)
- `MATRIX_DIM`, 16: square matrix dimension; element count is `MATRIX_DIM*MATRIX_DIM`
- `clk`  in  1  single clock; all logic is on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to begin a drain; ignored while `busy`
- `scale`  in  16  unsigned multiplier; sampled on start acceptance
- `shift`  in  5  right-shift amount (0..31); sampled on start acceptance
- `busy`  out  1  high from start acceptance until the `done` cycle, inclusive
- `done`  out  1  one-cycle pulse after the last output beat is accepted
- `rd_en`  out  1  accumulator memory read strobe
- `rd_addr`  out  $clog2(MATRIX_DIM*MATRIX_DIM)  element index
- `rd_data`  in  ACC_WIDTH  read data, valid the cycle after `rd_en`
- `out_valid`  out  1  output beat valid
- `out_ready`  in  1  downstream accept
- `out_data`  out  DATA_WIDTH  requantized element
- `out_last`  out  1  marks the final element (index `MATRIX_DIM*MATRIX_DIM-1`)

## Operation
- States:
  - IDLE: on `start`, go to RUN; latch `scale` and `shift`; clear the read address.
  - RUN: issue reads at addresses 0..N-1. After the read for address N-1 is issued, go to DRAIN.
  - DRAIN: wait until all in-flight reads complete and the FIFO is empty, with the last beat accepted. Then go to DONE.
  - DONE: `done`=1 for one cycle, then return to IDLE.
- Flow control is credit based:
  - `rd_en` asserts only when (FIFO occupancy + in-flight reads + results in the requant stage) < 4.
  - The FIFO can therefore never overflow.
  - No read data is dropped, and no read is issued twice.
- Arithmetic, one register stage:
  - p = signed(`rd_data`) × unsigned(`scale`), computed at full width ACC_WIDTH+17.
  - If `shift`>0, add 2^(`shift`-1) to p. This rounds half toward +∞.
  - Arithmetic right-shift by `shift`.
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- `out_last` travels with its element through the FIFO.
- A beat transfers when `out_valid` && `out_ready`. While `out_valid` is held high, `out_data` and `out_last` stay stable.
- Reset values, including on reset mid-operation:
  - State returns to IDLE and the FIFO is flushed.
  - `busy`, `done`, `rd_en`, `out_valid` and `out_last` are all 0.
  - `rd_addr` and `out_data` are 0.
- `start` asserted in any state other than IDLE has no effect.

## Timing
- `start` is sampled at edge E0. `rd_en` is high with `rd_addr`=0 in the cycle after E0.
- `rd_data` is captured at E2, the requant result is written into the FIFO at E2, and `out_valid` is high after E2.
- First-beat latency from `start` is therefore 2 cycles to `out_valid`.
- Throughput is 1 element/cycle when `out_ready` is held high.
- Minimum total drain time is N+3 cycles from `start` to `done`.
- `done` is asserted 1 cycle after the edge that accepts the `out_last` beat.
- `out_ready` low stalls reads within 3 cycles. Read issue resumes 1 cycle after space frees.

## Configuration
- `MATMUL_REQUANT_RELU_EN` defined: negative shifted values clamp to 0 before saturation. The output range is then [0, 2^(DATA_WIDTH-1)-1].
- Macro undefined: output is the full signed saturated range; no ReLU logic is present.

## Structure
- Package `matmul_pkg` holds:
  - the `DATA_WIDTH` and `ACC_WIDTH` default constants, shared with `tiled_matmul_engine`;
  - the state enum `requant_state_t` (IDLE, RUN, DRAIN, DONE);
  - the function `sat_signed`.
- Sub-module `requant_fifo`: 4-entry synchronous FIFO of {`out_last`, `out_data`} with occupancy count output.

## Test plan
- `scale`=1, `shift`=3, acc[0]=1000, acc[1]=12, acc[2]=-12 -> `out_data` 125, 2, -1 (0xFF). The values 2 and -1 confirm round-half-up.
- `scale`=1, `shift`=3, acc=1100 / -1100 -> 127 / -128 (0x80), confirming saturation. With `MATMUL_REQUANT_RELU_EN`, -1100 -> 0.
- `scale`=3, `shift`=0, acc = index i (0..255), `out_ready`=1 -> expected data = sat(3i). Checks:
  - `out_last` set only on beat 255;
  - `done` pulses exactly once, at 259 cycles after `start`.
- Random `out_ready` (50% duty) with random acc values -> all 256 beats are in order with no duplicates. `rd_en` never asserts with 4 credits in use.
- `rst` asserted mid-RUN at element 100 -> next cycle all outputs are 0. A following `start` restarts from `rd_addr`=0.
- `start` pulsed again during RUN with new `scale`/`shift` -> ignored: results still use the latched values and a single `done` is produced.

Source files
------------

// File: rtl/matmul_pkg.sv
// matmul_pkg: constants, types and helpers shared by the matmul datapath blocks.
//   DATA_WIDTH / ACC_WIDTH : default element and accumulator widths, also used
//                            by tiled_matmul_engine
//   requant_state_t        : drain controller states
//   sat_signed             : clamp a wide signed value to a signed w-bit range
package matmul_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned ACC_WIDTH  = 32;

  // Working width of sat_signed; callers sign-extend into it.
  localparam int unsigned SAT_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } requant_state_t;

  // Result lies in [-2^(w-1), 2^(w-1)-1]; the caller keeps the low w bits.
  function automatic logic signed [SAT_W-1:0] sat_signed(
    input logic signed [SAT_W-1:0] x,
    input int unsigned             w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
    lo = ~hi;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/requant_fifo.sv
// requant_fifo: small synchronous FIFO holding {out_last, out_data} beats.
//   clk, rst   : clock, synchronous active-high reset (flushes and zeroes)
//   push       : write push_data (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   head       : current head entry, stable until popped
//   count      : current occupancy 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module requant_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      // Storage is cleared too so the head reads as zero after reset.
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/matmul_result_requant.sv
// matmul_result_requant: drains the accumulator matrix in row-major order,
// requantizes each element (multiply, round-half-up shift, saturate) and
// streams it out on a valid/ready interface.
//   start/scale/shift : begin a drain; scale and shift latched on acceptance
//   busy/done         : busy from acceptance through the one-cycle done pulse
//   rd_en/rd_addr     : read request to the accumulator memory
//   rd_data           : read data, valid the cycle after rd_en
//   out_valid/out_ready/out_data/out_last : output beat stream
// Optional feature: define MATMUL_REQUANT_RELU_EN to clamp negative shifted
// values to zero before saturation.
module matmul_result_requant
  import matmul_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = matmul_pkg::DATA_WIDTH,
  parameter int unsigned ACC_WIDTH  = matmul_pkg::ACC_WIDTH,
  parameter int unsigned MATRIX_DIM = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [15:0]                               scale,
  input  logic [4:0]                                shift,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      rd_en,
  output logic [$clog2(MATRIX_DIM*MATRIX_DIM)-1:0]  rd_addr,
  input  logic [ACC_WIDTH-1:0]                      rd_data,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [DATA_WIDTH-1:0]                     out_data,
  output logic                                      out_last
);

  localparam int unsigned N_ELEM  = MATRIX_DIM * MATRIX_DIM;
  localparam int unsigned ADDR_W  = $clog2(N_ELEM);
  localparam int unsigned PROD_W  = ACC_WIDTH + 17;
  localparam int unsigned CREDITS = 4;
  localparam int unsigned CNT_W   = $clog2(CREDITS + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_ELEM - 1);

  requant_state_t          state;
  logic [15:0]             scale_q;
  logic [4:0]              shift_q;
  logic [ADDR_W-1:0]       next_addr;
  logic                    pend_valid;
  logic                    pend_last;
  logic [CNT_W-1:0]        fifo_count;
  logic [CNT_W-1:0]        count_after;
  logic                    pop;
  logic                    can_issue;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] bias;
  logic signed [PROD_W-1:0] shifted;
  logic [DATA_WIDTH-1:0]   requant;

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;

  // Credits in use after this edge = FIFO entries + the read whose data lands
  // next cycle + the read about to be issued. Keeping that at or below the
  // FIFO depth means every returning read has a guaranteed slot.
  always_comb begin
    count_after = fifo_count + CNT_W'(pend_valid) - CNT_W'(pop);
    can_issue   = (4'(count_after) + 4'(rd_en)) < 4'(CREDITS);
  end

  always_comb begin
    prod = PROD_W'($signed(rd_data)) * PROD_W'($signed({1'b0, scale_q}));
    bias = '0;
    if (shift_q != '0) bias[shift_q - 5'd1] = 1'b1;
    shifted = (prod + bias) >>> shift_q;
`ifdef MATMUL_REQUANT_RELU_EN
    if (shifted[PROD_W-1]) shifted = '0;
`endif
    requant = DATA_WIDTH'(sat_signed(SAT_W'(shifted), DATA_WIDTH));
  end

  requant_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (CREDITS)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pend_valid),
    .push_data ({pend_last, requant}),
    .pop       (pop),
    .head      ({out_last, out_data}),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      next_addr  <= '0;
      scale_q    <= '0;
      shift_q    <= '0;
      pend_valid <= 1'b0;
      pend_last  <= 1'b0;
    end else begin
      // Read issued last cycle returns data this cycle; it is pushed at the next edge.
      pend_valid <= rd_en;
      pend_last  <= rd_en && (rd_addr == LAST_ADDR);
      done       <= 1'b0;
      rd_en      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            scale_q   <= scale;
            shift_q   <= shift;
            busy      <= 1'b1;
            rd_en     <= 1'b1;
            rd_addr   <= '0;
            next_addr <= ADDR_W'(1);
            state     <= RUN;
          end
        end
        RUN: begin
          if (can_issue) begin
            rd_en     <= 1'b1;
            rd_addr   <= next_addr;
            next_addr <= next_addr + ADDR_W'(1);
            if (next_addr == LAST_ADDR) state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((fifo_count == '0) && !pend_valid && !rd_en) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
